// File: rtl/mole_round_controller_pkg.sv
// mole_round_controller_pkg: shared state encoding, LFSR constants and field widths
package mole_round_controller_pkg;
   typedef enum logic [2:0] {IDLE, DOWN, SPAWN, UP, OVER} state_t;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // taps 16,14,13,11 of a right-shifting Fibonacci register land on bits 0,2,3,5
   localparam logic [15:0] LFSR_TAPS = 16'h002D;
   localparam int SCORE_W = 16;
   localparam int LIVES_W = 4;
   localparam int LEVEL_W = 8;
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction
endpackage

// File: rtl/mole_round_controller_ms_timer.sv
// mole_round_controller_ms_timer: ms prescaler plus phase counter; done marks the final ms of load_ms
module mole_round_controller_ms_timer #(
   parameter int CLKS_PER_MS = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic [19:0] load_ms,
   output logic        ms_tick,
   output logic        done
);
   localparam int PW = $clog2(CLKS_PER_MS + 1);
   logic [PW-1:0] pre;
   logic [19:0]   phase;
   assign ms_tick = pre == PW'(CLKS_PER_MS - 1);
   assign done    = phase == load_ms - 20'd1;
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         pre   <= '0;
         phase <= '0;
      end else begin
         pre   <= ms_tick ? '0 : pre + PW'(1);
         phase <= ms_tick ? phase + 20'd1 : phase;
      end
   end
endmodule

// File: rtl/mole_round_controller.sv
// mole_round_controller: whack-a-mole game sequencer; spawns moles, times up/down phases,
// tracks score, lives and level from the hit-detection pulses.
module mole_round_controller
   import mole_round_controller_pkg::*;
#(
   parameter int NUM_HOLES        = 18,
   parameter int CLKS_PER_MS      = 50000,
   parameter int UP_MS_INIT       = 1500,
   parameter int UP_MS_MIN        = 400,
   parameter int UP_MS_STEP       = 100,
   parameter int DOWN_MS          = 500,
   parameter int START_LIVES      = 3,
   parameter int MAX_MOLES        = 3,
   parameter int FULL_CLEAR_BONUS = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 miss,
   input  logic                 non_full_clear_hit,
   input  logic                 full_clear_hit,
   output logic [NUM_HOLES-1:0] mole_positions,
   output logic                 game_in_progress,
   output logic [SCORE_W-1:0]   score,
   output logic [LIVES_W-1:0]   lives,
   output logic [LEVEL_W-1:0]   level,
   output logic                 game_over
);
   localparam int SW1 = SCORE_W + 1;
   state_t               state;
   logic [15:0]          lfsr, idx;
   logic [NUM_HOLES-1:0] staging, pick;
   logic [LEVEL_W-1:0]   spawn_cnt, spawn_base, spawn_k;
   logic [19:0]          dec, diff, up_ms, load_ms;
   logic [SW1-1:0]       score_sum;
   logic                 ms_tick, last_ms, expire, clr, up_end, lose;
   assign idx        = lfsr % 16'(NUM_HOLES);
   assign pick       = NUM_HOLES'(1) << idx;
   assign spawn_base = (level >> 2) + LEVEL_W'(1);
   assign spawn_k    = spawn_base > LEVEL_W'(MAX_MOLES) ? LEVEL_W'(MAX_MOLES) : spawn_base;
   assign dec        = 20'(level) * 20'(UP_MS_STEP);
   assign diff       = dec >= 20'(UP_MS_INIT) ? 20'd0 : 20'(UP_MS_INIT) - dec;
   assign up_ms      = diff > 20'(UP_MS_MIN) ? diff : 20'(UP_MS_MIN);
   assign load_ms    = state == UP ? up_ms : 20'(DOWN_MS);
   assign expire     = ms_tick && last_ms;
   assign up_end     = state == UP && (expire || full_clear_hit);
   // timer sits cleared outside timed phases so each DOWN/UP entry starts from zero
   assign clr        = !(state == DOWN || state == UP) || expire || up_end;
   assign lose       = game_in_progress && miss && lives == LIVES_W'(1);
   assign score_sum  = {1'b0, score} + SW1'(non_full_clear_hit)
                     + (full_clear_hit ? SW1'(1 + FULL_CLEAR_BONUS) : SW1'(0));
   mole_round_controller_ms_timer #(.CLKS_PER_MS(CLKS_PER_MS)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .load_ms (load_ms),
      .ms_tick (ms_tick),
      .done    (last_ms)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         lfsr             <= LFSR_SEED;
         mole_positions   <= '0;
         game_in_progress <= 1'b0;
         score            <= '0;
         lives            <= LIVES_W'(START_LIVES);
         level            <= '0;
         game_over        <= 1'b0;
         staging          <= '0;
         spawn_cnt        <= '0;
      end else begin
         lfsr <= lfsr_next(lfsr);
         if (game_in_progress) begin
            score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            if (miss && lives != '0) lives <= lives - LIVES_W'(1);
         end
         if (lose) begin
            state            <= OVER;
            game_in_progress <= 1'b0;
            game_over        <= 1'b1;
            mole_positions   <= '0;
         end else begin
            case (state)
               IDLE, OVER: if (start) begin
                  state            <= DOWN;
                  game_in_progress <= 1'b1;
                  game_over        <= 1'b0;
                  score            <= '0;
                  level            <= '0;
                  lives            <= LIVES_W'(START_LIVES);
               end
               DOWN: begin
                  staging   <= '0;
                  spawn_cnt <= '0;
                  if (expire) state <= SPAWN;
               end
               SPAWN: begin
                  staging   <= staging | pick;
                  spawn_cnt <= spawn_cnt + LEVEL_W'(1);
                  if (spawn_cnt == spawn_k - LEVEL_W'(1)) begin
                     state          <= UP;
                     mole_positions <= staging | pick;
                  end
               end
               UP: if (up_end) begin
                  state          <= DOWN;
                  mole_positions <= '0;
                  level          <= level == '1 ? level : level + LEVEL_W'(1);
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mole_round_controller.sv
// tb_mole_round_controller: randomized scenario bench against a phase-level game model
module tb_mole_round_controller;
   localparam int CPM = 2, UPI = 6, UPMIN = 2, UPS = 2, DMS = 3, SL = 3, NH = 18, MM = 3, BON = 2;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, miss = 1'b0;
   logic non_full_clear_hit = 1'b0, full_clear_hit = 1'b0;
   logic [NH-1:0] mole_positions;
   logic game_in_progress, game_over;
   logic [15:0] score;
   logic [3:0] lives;
   logic [7:0] level;
   int compared = 0, mismatched = 0;
   int m_score, m_lives, m_level;
   bit m_gip;

   always #5 clk = ~clk;

   mole_round_controller #(
      .NUM_HOLES(NH), .CLKS_PER_MS(CPM), .UP_MS_INIT(UPI), .UP_MS_MIN(UPMIN), .UP_MS_STEP(UPS),
      .DOWN_MS(DMS), .START_LIVES(SL), .MAX_MOLES(MM), .FULL_CLEAR_BONUS(BON)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .miss(miss),
      .non_full_clear_hit(non_full_clear_hit), .full_clear_hit(full_clear_hit),
      .mole_positions(mole_positions), .game_in_progress(game_in_progress),
      .score(score), .lives(lives), .level(level), .game_over(game_over)
   );

   function automatic int exp_k(int l);
      return (1 + l / 4 < MM) ? 1 + l / 4 : MM;
   endfunction
   function automatic int exp_up(int l);
      int ms = UPI - l * UPS;
      return (ms > UPMIN ? ms : UPMIN) * CPM;
   endfunction
   function automatic int exp_zero(int l);
      return DMS * CPM + exp_k(l);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one cycle of stimulus with the game model updated for that cycle's pulses
   task automatic drive(input bit m, input bit nf, input bit fc, input bit st);
      miss = m; non_full_clear_hit = nf; full_clear_hit = fc; start = st;
      if (m_gip) begin
         m_score += int'(nf) + (fc ? 1 + BON : 0);
         if (m_score > 65535) m_score = 65535;
         if (m && m_lives > 0) begin
            m_lives--;
            if (m_lives == 0) m_gip = 0;
         end
      end else if (st) begin
         m_gip = 1; m_score = 0; m_level = 0; m_lives = SL;
      end
      tick();
      miss = 0; non_full_clear_hit = 0; full_clear_hit = 0; start = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      tick();
      reset = 0;
      m_score = 0; m_lives = SL; m_level = 0; m_gip = 0;
   endtask

   task automatic count_zero(output int n);
      n = 0;
      while (mole_positions == '0 && n < 200) begin
         n++;
         tick();
      end
   endtask

   task automatic count_up(input int fc_at, input logic [31:0] nf_mask, output int n,
                           output bit stable, output logic [NH-1:0] pos);
      pos = mole_positions;
      n = 0;
      stable = 1;
      while (mole_positions != '0 && n < 200) begin
         if (mole_positions !== pos) stable = 0;
         drive(0, n < 32 && nf_mask[n % 32], n == fc_at, 0);
         n++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      compared += 6;
      if (mole_positions !== '0) begin mismatched++; $display("FAIL reset_moles got %h want 0", mole_positions); end
      if (game_in_progress !== 1'b0) begin mismatched++; $display("FAIL reset_gip got %b want 0", game_in_progress); end
      if (score !== 16'd0) begin mismatched++; $display("FAIL reset_score got %0d want 0", score); end
      if (lives !== 4'(SL)) begin mismatched++; $display("FAIL reset_lives got %0d want %0d", lives, SL); end
      if (level !== 8'd0) begin mismatched++; $display("FAIL reset_level got %0d want 0", level); end
      if (game_over !== 1'b0) begin mismatched++; $display("FAIL reset_over got %b want 0", game_over); end
   endtask

   task automatic test_start();
      int n; bit st; logic [NH-1:0] pos;
      do_reset();
      drive(0, 0, 0, 1);
      compared += 2;
      if (game_in_progress !== 1'b1) begin mismatched++; $display("FAIL start_gip got %b want 1", game_in_progress); end
      if (mole_positions !== '0) begin mismatched++; $display("FAIL start_moles got %h want 0", mole_positions); end
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 1);
      count_zero(n);
      compared++;
      if (n != exp_zero(0) - 2) begin mismatched++; $display("FAIL start_down_spawn got %0d want %0d", n, exp_zero(0) - 2); end
      count_up(-1, 0, n, st, pos);
      m_level++;
      compared += 4;
      if (n != exp_up(0)) begin mismatched++; $display("FAIL start_up_len got %0d want %0d", n, exp_up(0)); end
      if (!st) begin mismatched++; $display("FAIL start_up_stable got 0 want 1"); end
      if ($countones(pos) != 1) begin mismatched++; $display("FAIL start_onehot got %h want one bit", pos); end
      if (level !== 8'(m_level)) begin mismatched++; $display("FAIL start_level got %0d want %0d", level, m_level); end
   endtask

   task automatic test_timeout();
      int n; bit st; logic [NH-1:0] pos;
      do_reset();
      drive(0, 0, 0, 1);
      count_zero(n);
      count_up(-1, 0, n, st, pos);
      m_level++;
      compared += 2;
      if (level !== 8'(m_level)) begin mismatched++; $display("FAIL timeout_level got %0d want %0d", level, m_level); end
      if (mole_positions !== '0) begin mismatched++; $display("FAIL timeout_moles got %h want 0", mole_positions); end
      drive(1, 0, 0, 0);
      compared++;
      if (lives !== 4'(m_lives)) begin mismatched++; $display("FAIL timeout_lives got %0d want %0d", lives, m_lives); end
      count_zero(n);
      compared++;
      if (n != exp_zero(1) - 1) begin mismatched++; $display("FAIL timeout_down2 got %0d want %0d", n, exp_zero(1) - 1); end
      count_up(-1, 0, n, st, pos);
      m_level++;
      compared += 2;
      if (n != exp_up(1)) begin mismatched++; $display("FAIL timeout_up2_len got %0d want %0d", n, exp_up(1)); end
      if (level !== 8'(m_level)) begin mismatched++; $display("FAIL timeout_level2 got %0d want %0d", level, m_level); end
   endtask

   task automatic test_full_clear();
      int n; bit st; logic [NH-1:0] pos;
      do_reset();
      drive(0, 0, 0, 1);
      count_zero(n);
      count_up(3, 0, n, st, pos);
      m_level++;
      compared += 4;
      if (n != 4) begin mismatched++; $display("FAIL fc_up_len got %0d want 4", n); end
      if (score !== 16'(m_score)) begin mismatched++; $display("FAIL fc_score got %0d want %0d", score, m_score); end
      if (level !== 8'(m_level)) begin mismatched++; $display("FAIL fc_level got %0d want %0d", level, m_level); end
      if (mole_positions !== '0) begin mismatched++; $display("FAIL fc_moles got %h want 0", mole_positions); end
      count_zero(n);
      compared++;
      if (n != exp_zero(1)) begin mismatched++; $display("FAIL fc_next_down got %0d want %0d", n, exp_zero(1)); end
   endtask

   task automatic test_game_over();
      int hits;
      do_reset();
      drive(0, 0, 0, 1);
      hits = $urandom_range(1, 5);
      for (int i = 0; i < hits; i++) drive(0, 1, 0, 0);
      for (int i = 0; i < 3; i++) drive(1, 1'($urandom_range(0, 1)), 0, 0);
      compared += 5;
      if (lives !== 4'd0) begin mismatched++; $display("FAIL over_lives got %0d want 0", lives); end
      if (game_over !== 1'b1) begin mismatched++; $display("FAIL over_flag got %b want 1", game_over); end
      if (game_in_progress !== 1'b0) begin mismatched++; $display("FAIL over_gip got %b want 0", game_in_progress); end
      if (mole_positions !== '0) begin mismatched++; $display("FAIL over_moles got %h want 0", mole_positions); end
      if (score !== 16'(m_score)) begin mismatched++; $display("FAIL over_score got %0d want %0d", score, m_score); end
      drive(1, 1, 0, 0);
      for (int i = 0; i < int'($urandom_range(0, 4)); i++) drive(0, 0, 1, 0);
      compared += 3;
      if (lives !== 4'd0) begin mismatched++; $display("FAIL over_late_miss got %0d want 0", lives); end
      if (score !== 16'(m_score)) begin mismatched++; $display("FAIL over_held_score got %0d want %0d", score, m_score); end
      if (game_over !== 1'b1) begin mismatched++; $display("FAIL over_held_flag got %b want 1", game_over); end
      drive(0, 0, 0, 1);
      compared += 4;
      if (lives !== 4'(SL)) begin mismatched++; $display("FAIL restart_lives got %0d want %0d", lives, SL); end
      if (score !== 16'd0) begin mismatched++; $display("FAIL restart_score got %0d want 0", score); end
      if (game_in_progress !== 1'b1) begin mismatched++; $display("FAIL restart_gip got %b want 1", game_in_progress); end
      if (game_over !== 1'b0) begin mismatched++; $display("FAIL restart_over got %b want 0", game_over); end
   endtask

   task automatic test_levels();
      int n, fc_at; bit st; logic [NH-1:0] pos;
      do_reset();
      drive(0, 0, 0, 1);
      for (int r = 0; r < 9; r++) begin
         count_zero(n);
         compared++;
         if (n != exp_zero(m_level)) begin mismatched++; $display("FAIL lvl%0d_zero got %0d want %0d", r, n, exp_zero(m_level)); end
         fc_at = (r == 3) ? exp_up(m_level) - 1 :
                 (r == 8 || $urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, exp_up(m_level) - 1));
         count_up(fc_at, r == 8 ? 32'd0 : $urandom, n, st, pos);
         compared += 4;
         if (n != (fc_at < 0 ? exp_up(m_level) : fc_at + 1)) begin
            mismatched++; $display("FAIL lvl%0d_up_len got %0d want %0d", r, n, fc_at < 0 ? exp_up(m_level) : fc_at + 1);
         end
         if (!st) begin mismatched++; $display("FAIL lvl%0d_stable got 0 want 1", r); end
         if ($countones(pos) < 1 || $countones(pos) > exp_k(m_level)) begin
            mismatched++; $display("FAIL lvl%0d_moles got %0d bits want 1..%0d", r, $countones(pos), exp_k(m_level));
         end
         m_level++;
         if (level !== 8'(m_level) || score !== 16'(m_score)) begin
            mismatched++; $display("FAIL lvl%0d_counts got lvl %0d score %0d want lvl %0d score %0d", r, level, score, m_level, m_score);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      drive(0, 0, 0, 1);
      count_zero(n);
      for (int i = 0; i < 5; i++) drive(0, 1, 0, 0);
      compared++;
      if (score !== 16'd5 || mole_positions == '0) begin
         mismatched++; $display("FAIL mid_setup got score %0d moles %h want 5 nonzero", score, mole_positions);
      end
      do_reset();
      compared++;
      if ({mole_positions, game_in_progress, score, lives, level, game_over} !== {18'd0, 1'b0, 16'd0, 4'(SL), 8'd0, 1'b0}) begin
         mismatched++; $display("FAIL mid_reset got m%h g%b s%0d l%0d v%0d o%b want all reset", mole_positions,
                                game_in_progress, score, lives, level, game_over);
      end
      drive(0, 1, 0, 0);
      drive(0, 0, 1, 0);
      drive(1, 0, 0, 0);
      compared += 2;
      if (score !== 16'd0) begin mismatched++; $display("FAIL idle_hits got %0d want 0", score); end
      if (lives !== 4'(SL) || game_in_progress !== 1'b0) begin
         mismatched++; $display("FAIL idle_state got lives %0d gip %b want %0d 0", lives, game_in_progress, SL);
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_timeout();
      test_full_clear();
      test_game_over();
      test_levels();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
